// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Transmit half of a 16550-style UART. Bytes written by the register interface
// are queued in a small FIFO and then serialised onto stx_pad_o. The frame is
// a start bit, 5-8 data bits sent LSB first, an optional parity bit and
// 1/1.5/2 stop bits. Bit timing is taken from the shared 16x baud strobe
// `enable`, so one bit lasts 16 ticks.
//
// Handshake: there is no ready/valid back-pressure on the write side. A byte
// is offered by holding tf_push high for exactly one clk. It is stored when the
// FIFO has room, or when the FIFO is full but the serializer pops in that same
// clk. Otherwise it is dropped and tf_overrun pulses high for one clk.
//
// Ports
//   clk         in   system clock
//   wb_rst_i    in   asynchronous active-high reset
//   lcr         in   line control: [1:0] word length (00=5 .. 11=8 bits),
//                    [2] stop length, [3] parity enable, [4] even parity,
//                    [5] stick parity, [6] break
//   enable      in   16x baud tick, single-cycle strobe
//   tf_push     in   write tf_data_in into the FIFO
//   tf_data_in  in   byte to transmit
//   tx_reset    in   synchronous flush of the FIFO and the serializer
//   stx_pad_o   out  serial line, idle high
//   tf_count    out  number of bytes held in the FIFO
//   tf_overrun  out  one-cycle pulse: push attempted while the FIFO was full
//   thre        out  FIFO empty
//   temt        out  FIFO empty and serializer idle
//
// The serializer state lives in r_state (type state_t) so that checkers can
// bind to it hierarchically.
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
   parameter int FIFO_DEPTH = 16,
   parameter int FIFO_CNT_W = 5
) (
   input  logic                  clk,
   input  logic                  wb_rst_i,
   input  logic [7:0]            lcr,
   input  logic                  enable,
   input  logic                  tf_push,
   input  logic [7:0]            tf_data_in,
   input  logic                  tx_reset,
   output logic                  stx_pad_o,
   output logic [FIFO_CNT_W-1:0] tf_count,
   output logic                  tf_overrun,
   output logic                  thre,
   output logic                  temt
);

   localparam int                    PTR_W    = $clog2(FIFO_DEPTH);
   localparam logic [FIFO_CNT_W-1:0] FULL_CNT = FIFO_CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   // ---------------------------------------------------------------------------
   // FIFO
   // ---------------------------------------------------------------------------
   logic [7:0]            r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [FIFO_CNT_W-1:0] r_count;
   logic [FIFO_CNT_W-1:0] w_count_next;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_pop;
   logic                  w_push;
   logic [7:0]            w_head;

   // ---------------------------------------------------------------------------
   // Serializer
   // ---------------------------------------------------------------------------
   state_t     r_state;
   state_t     w_state_next;
   logic [3:0] r_cnt16;
   logic [3:0] w_cnt16_next;
   logic [2:0] r_bitcnt;
   logic [2:0] w_bitcnt_next;
   logic [7:0] r_tshift;
   logic [7:0] w_tshift_next;
   logic       r_line;
   logic       w_line_next;
   logic       r_stop_half;
   logic       w_stop_half_next;

   // Frame format captured when the byte is popped, so that lcr changes in
   // the middle of a frame only apply to the following frame.
   logic       r_pe;
   logic       r_par_bit;
   logic       r_stop2;
   logic       r_wlen5;

   logic [7:0] w_mask;
   logic       w_xor;
   logic       w_par_bit;

   logic       r_stx_pad;
   logic       r_overrun;
   logic       r_thre;
   logic       r_temt;

   // lcr[7] (divisor latch access) belongs to the register block.
   logic       w_unused;
   assign w_unused = lcr[7];

   assign w_full  = (r_count == FULL_CNT);
   assign w_empty = (r_count == '0);
   assign w_head  = r_mem[r_rd_ptr];

   // The serializer only pulls a byte from IDLE on a baud tick. A flush takes
   // priority over everything else in the same clk.
   assign w_pop  = (r_state == S_IDLE) && enable && !w_empty && !tx_reset;
   // A full FIFO still accepts a byte when a pop frees a slot in the same clk.
   assign w_push = tf_push && !tx_reset && (!w_full || w_pop);

   always_comb begin
      w_count_next = r_count;
      if (tx_reset) begin
         w_count_next = '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + FIFO_CNT_W'(1);
            2'b01:   w_count_next = r_count - FIFO_CNT_W'(1);
            default: w_count_next = r_count;
         endcase
      end
   end

   // Storage has no reset; only entries between the pointers are meaningful.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= tf_data_in;
      end
   end

   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_count <= w_count_next;
         if (tx_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            // Pointers wrap naturally because FIFO_DEPTH is a power of two.
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Parity of the byte about to be popped. Only the active word-length bits
   // take part in the XOR.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_mask = 8'hFF;
      case (lcr[1:0])
         2'b00:   w_mask = 8'h1F;
         2'b01:   w_mask = 8'h3F;
         2'b10:   w_mask = 8'h7F;
         default: w_mask = 8'hFF;
      endcase
   end

   assign w_xor = ^(w_head & w_mask);

   always_comb begin
      w_par_bit = 1'b0;
      case ({lcr[5], lcr[4]})
         2'b00:   w_par_bit = ~w_xor;  // odd
         2'b01:   w_par_bit = w_xor;   // even
         2'b10:   w_par_bit = 1'b1;    // stick one
         default: w_par_bit = 1'b0;    // stick zero
      endcase
   end

   // ---------------------------------------------------------------------------
   // Serializer FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state     <= S_IDLE;
         r_cnt16     <= '0;
         r_bitcnt    <= '0;
         r_tshift    <= '0;
         r_line      <= 1'b1;
         r_stop_half <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cnt16     <= w_cnt16_next;
         r_bitcnt    <= w_bitcnt_next;
         r_tshift    <= w_tshift_next;
         r_line      <= w_line_next;
         r_stop_half <= w_stop_half_next;
      end
   end

   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_pe      <= 1'b0;
         r_par_bit <= 1'b0;
         r_stop2   <= 1'b0;
         r_wlen5   <= 1'b0;
      end else if (w_pop) begin
         r_pe      <= lcr[3];
         r_par_bit <= w_par_bit;
         r_stop2   <= lcr[2];
         r_wlen5   <= (lcr[1:0] == 2'b00);
      end
   end

   // ---------------------------------------------------------------------------
   // Serializer FSM: next state. A bit ends on the tick where r_cnt16 is 0;
   // that same tick drives the next bit and reloads the counter with 15.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_next     = r_state;
      w_cnt16_next     = r_cnt16;
      w_bitcnt_next    = r_bitcnt;
      w_tshift_next    = r_tshift;
      w_line_next      = r_line;
      w_stop_half_next = r_stop_half;

      if (tx_reset) begin
         w_state_next     = S_IDLE;
         w_cnt16_next     = '0;
         w_line_next      = 1'b1;
         w_stop_half_next = 1'b0;
      end else if (enable) begin
         case (r_state)
            S_IDLE: begin
               w_line_next = 1'b1;
               if (!w_empty) begin
                  w_tshift_next    = w_head;
                  w_bitcnt_next    = {1'b0, lcr[1:0]} + 3'd4;
                  w_line_next      = 1'b0;
                  w_cnt16_next     = 4'd15;
                  w_stop_half_next = 1'b0;
                  w_state_next     = S_START;
               end
            end

            S_START: begin
               if (r_cnt16 == 4'd0) begin
                  w_line_next   = r_tshift[0];
                  w_tshift_next = {1'b0, r_tshift[7:1]};
                  w_cnt16_next  = 4'd15;
                  w_state_next  = S_DATA;
               end else begin
                  w_cnt16_next = r_cnt16 - 4'd1;
               end
            end

            S_DATA: begin
               if (r_cnt16 == 4'd0) begin
                  w_cnt16_next = 4'd15;
                  if (r_bitcnt == 3'd0) begin
                     if (r_pe) begin
                        w_line_next  = r_par_bit;
                        w_state_next = S_PARITY;
                     end else begin
                        w_line_next  = 1'b1;
                        w_state_next = S_STOP;
                     end
                  end else begin
                     w_line_next   = r_tshift[0];
                     w_tshift_next = {1'b0, r_tshift[7:1]};
                     w_bitcnt_next = r_bitcnt - 3'd1;
                  end
               end else begin
                  w_cnt16_next = r_cnt16 - 4'd1;
               end
            end

            S_PARITY: begin
               if (r_cnt16 == 4'd0) begin
                  w_line_next  = 1'b1;
                  w_cnt16_next = 4'd15;
                  w_state_next = S_STOP;
               end else begin
                  w_cnt16_next = r_cnt16 - 4'd1;
               end
            end

            S_STOP: begin
               w_line_next = 1'b1;
               if (r_cnt16 == 4'd0) begin
                  // Long stop: after the first 16 ticks run a second segment
                  // of 8 ticks (5-bit words) or 16 ticks (all other lengths).
                  if (r_stop2 && !r_stop_half) begin
                     w_stop_half_next = 1'b1;
                     w_cnt16_next     = r_wlen5 ? 4'd7 : 4'd15;
                  end else begin
                     w_stop_half_next = 1'b0;
                     w_state_next     = S_IDLE;
                  end
               end else begin
                  w_cnt16_next = r_cnt16 - 4'd1;
               end
            end

            default: begin
               w_state_next = S_IDLE;
               w_line_next  = 1'b1;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Registered outputs. Break forces the pad low while the FSM keeps running
   // underneath, so releasing break resumes at the current frame position.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_stx_pad <= 1'b1;
         r_overrun <= 1'b0;
         r_thre    <= 1'b1;
         r_temt    <= 1'b1;
      end else begin
         r_stx_pad <= w_line_next & ~lcr[6];
         r_overrun <= tf_push && !tx_reset && w_full && !w_pop;
         r_thre    <= (w_count_next == '0);
         r_temt    <= (w_count_next == '0) && (w_state_next == S_IDLE);
      end
   end

   assign stx_pad_o  = r_stx_pad;
   assign tf_count   = r_count;
   assign tf_overrun = r_overrun;
   assign thre       = r_thre;
   assign temt       = r_temt;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Bench for uart_tx_serializer. A frame table drives single-byte frames of
// several formats; a tick-level monitor decodes the serial line against an
// expected-frame queue. Hand-written sequences cover FIFO full/overrun,
// push+pop on a full FIFO, back-to-back frames, mid-frame lcr change,
// tx_reset mid-frame and break.
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

   logic       clk;
   logic       wb_rst_i;
   logic [7:0] lcr;
   logic       enable;
   logic       tf_push;
   logic [7:0] tf_data_in;
   logic       tx_reset;
   logic       stx_pad_o;
   logic [4:0] tf_count;
   logic       tf_overrun;
   logic       thre;
   logic       temt;

   uart_tx_serializer #(
      .FIFO_DEPTH(16),
      .FIFO_CNT_W(5)
   ) dut (
      .clk       (clk),
      .wb_rst_i  (wb_rst_i),
      .lcr       (lcr),
      .enable    (enable),
      .tf_push   (tf_push),
      .tf_data_in(tf_data_in),
      .tx_reset  (tx_reset),
      .stx_pad_o (stx_pad_o),
      .tf_count  (tf_count),
      .tf_overrun(tf_overrun),
      .thre      (thre),
      .temt      (temt)
   );

   // bits: transmitted bits after the start bit, first one in bit 0
   typedef struct {
      logic [7:0] lcr;
      logic [7:0] data;
      logic [8:0] bits;
      int         n;
      int         stop;
   } vec_t;

   typedef struct {
      logic [8:0] bits;
      int         n;
      int         stop;
      bit         chk_temt;
      bit         chk_gap;
   } frame_t;

   localparam int NV = 11;

   vec_t   vecs [NV];
   frame_t exp_q[$];

   int n_vec;
   int n_err;
   int ena_mode;   // 0 = no ticks, 1 = tick every 4 clk, 2 = driven by hand
   bit mon_en;
   int clk_no;

   // monitor state
   bit         busy;
   frame_t     cur;
   bit         cur_valid;
   int         idx;
   int         temt_idx;
   int         idle_run;
   logic [8:0] obs;
   bit         start_bad;
   bit         stop_bad;

   // ---------------------------------------------------------------------------
   // clock / reset-independent generators
   // ---------------------------------------------------------------------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      clk_no = 0;
      forever begin
         @(posedge clk);
         clk_no++;
      end
   end

   initial begin
      int div;
      div = 0;
      forever begin
         @(posedge clk);
         #1;
         if (ena_mode == 1) begin
            div    = (div + 1) % 4;
            enable = (div == 0);
         end else if (ena_mode == 0) begin
            enable = 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // scoreboard helpers
   // ---------------------------------------------------------------------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic start_frame(input int gap);
      if (exp_q.size() == 0) begin
         chk("unexpected_frame", 32'd1, 32'd0);
         cur_valid    = 1'b0;
         cur.bits     = '0;
         cur.n        = 8;
         cur.stop     = 16;
         cur.chk_temt = 1'b0;
         cur.chk_gap  = 1'b0;
      end else begin
         cur       = exp_q.pop_front();
         cur_valid = 1'b1;
         if (cur.chk_gap) chk("frame_gap", gap, 32'd0);
      end
      busy      = 1'b1;
      idx       = 0;
      obs       = '0;
      start_bad = 1'b0;
      stop_bad  = 1'b0;
      temt_idx  = -1;
   endtask

   task automatic end_frame(input int end_idx);
      if (cur_valid) begin
         chk("frame_bits", obs, cur.bits);
         chk("start_bit", start_bad, 32'd0);
         chk("stop_level", stop_bad, 32'd0);
         if (cur.chk_temt) chk("temt_tick", temt_idx, end_idx);
      end
      busy     = 1'b0;
      idle_run = 0;
   endtask

   // Tick monitor: one line sample per baud tick, taken at the negedge after
   // the clk edge on which the DUT saw enable. Sample 0 is the first start-bit
   // sample; each bit is read in its middle (offset 8).
   initial begin
      bit t;
      int stop_start;
      int end_idx;
      busy     = 1'b0;
      idle_run = 0;
      forever begin
         @(posedge clk);
         t = enable;
         @(negedge clk);
         if (!mon_en) begin
            busy     = 1'b0;
            idle_run = 0;
         end else if (t) begin
            if (!busy) begin
               if (stx_pad_o === 1'b0) start_frame(idle_run);
               else idle_run++;
            end else begin
               idx++;
               stop_start = 16 * (cur.n + 1);
               end_idx    = stop_start + cur.stop;
               if (idx < 16 && stx_pad_o !== 1'b0) start_bad = 1'b1;
               if (idx >= 16 && idx < stop_start && (idx % 16) == 8)
                  obs[idx/16 - 1] = stx_pad_o;
               if (idx >= stop_start && idx < end_idx && stx_pad_o !== 1'b1)
                  stop_bad = 1'b1;
               if (temt === 1'b1 && temt_idx < 0) temt_idx = idx;
               if (idx == end_idx) begin
                  end_frame(end_idx);
                  if (stx_pad_o === 1'b0) start_frame(0);
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // driver tasks
   // ---------------------------------------------------------------------------
   task automatic push_byte(input logic [7:0] d);
      @(posedge clk);
      #1;
      tf_push    = 1'b1;
      tf_data_in = d;
      @(posedge clk);
      #1;
      tf_push = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      bit done;
      done = 1'b0;
      for (int i = 0; i < limit && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy && temt === 1'b1) done = 1'b1;
      end
      chk("drain_in_time", done, 32'd1);
   endtask

   task automatic expect_frame(input logic [8:0] bits, input int n, input int stop,
                               input bit chk_temt, input bit chk_gap);
      frame_t f;
      f.bits     = bits;
      f.n        = n;
      f.stop     = stop;
      f.chk_temt = chk_temt;
      f.chk_gap  = chk_gap;
      exp_q.push_back(f);
   endtask

   // ---------------------------------------------------------------------------
   // watchdog
   // ---------------------------------------------------------------------------
   initial begin
      #3_000_000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // ---------------------------------------------------------------------------
   // main test
   // ---------------------------------------------------------------------------
   initial begin
      logic [7:0] d;
      int         bad;
      int         t0;
      bit         seen;

      n_vec      = 0;
      n_err      = 0;
      wb_rst_i   = 1'b1;
      lcr        = 8'h03;
      enable     = 1'b0;
      tf_push    = 1'b0;
      tf_data_in = 8'h00;
      tx_reset   = 1'b0;
      ena_mode   = 0;
      mon_en     = 1'b0;

      //                 lcr    data   bits    n  stop
      vecs[0]  = '{8'h03, 8'hA5, 9'h0A5, 8, 16};  // 8N1
      vecs[1]  = '{8'h1B, 8'h07, 9'h107, 9, 16};  // 8E1, parity 1
      vecs[2]  = '{8'h0B, 8'h07, 9'h007, 9, 16};  // 8O1, parity 0
      vecs[3]  = '{8'h2B, 8'h07, 9'h107, 9, 16};  // stick 1
      vecs[4]  = '{8'h3B, 8'h07, 9'h007, 9, 16};  // stick 0
      vecs[5]  = '{8'h04, 8'h13, 9'h013, 5, 24};  // 5 bits, 1.5 stop
      vecs[6]  = '{8'h07, 8'h3C, 9'h03C, 8, 32};  // 8 bits, 2 stop
      vecs[7]  = '{8'h1A, 8'hFF, 9'h0FF, 8, 16};  // 7E1, bit 7 not in parity
      vecs[8]  = '{8'h08, 8'hE0, 9'h020, 6, 16};  // 5O1, upper bits ignored
      vecs[9]  = '{8'h05, 8'h2A, 9'h02A, 6, 32};  // 6 bits, 2 stop
      vecs[10] = '{8'h0E, 8'h55, 9'h0D5, 8, 32};  // 7O2

      // reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stx", stx_pad_o, 32'd1);
      chk("rst_count", tf_count, 32'd0);
      chk("rst_overrun", tf_overrun, 32'd0);
      chk("rst_thre", thre, 32'd1);
      chk("rst_temt", temt, 32'd1);
      wb_rst_i = 1'b0;
      @(posedge clk);
      #1;
      ena_mode = 1;
      mon_en   = 1'b1;

      // frame table
      for (int v = 0; v < NV; v++) begin
         lcr = vecs[v].lcr;
         expect_frame(vecs[v].bits, vecs[v].n, vecs[v].stop, 1'b1, 1'b0);
         push_byte(vecs[v].data);
         wait_done(4000);
      end

      // lcr changed after the pop must not affect the current frame
      lcr = 8'h03;
      expect_frame(9'h0A5, 8, 16, 1'b1, 1'b0);
      push_byte(8'hA5);
      for (int i = 0; i < 200 && !busy; i++) @(posedge clk);
      #1;
      lcr = 8'h3F;
      wait_done(4000);
      lcr = 8'h03;

      // fill the FIFO with no ticks, overrun on the 17th byte
      ena_mode = 0;
      repeat (2) @(posedge clk);
      for (int i = 0; i < 17; i++) begin
         d = 8'($urandom_range(0, 255));
         if (i < 16) expect_frame({1'b0, d}, 8, 16, 1'b0, (i > 0));
         push_byte(d);
         chk("overrun_pulse", tf_overrun, (i == 16) ? 32'd1 : 32'd0);
      end
      chk("full_count", tf_count, 32'd16);
      chk("full_thre", thre, 32'd0);
      @(posedge clk);
      #1;
      chk("overrun_one_cycle", tf_overrun, 32'd0);

      // push into the full FIFO on the same clk as a pop
      ena_mode = 2;
      @(posedge clk);
      #1;
      d = 8'h96;
      expect_frame({1'b0, d}, 8, 16, 1'b1, 1'b1);
      enable     = 1'b1;
      tf_push    = 1'b1;
      tf_data_in = d;
      @(posedge clk);
      #1;
      enable  = 1'b0;
      tf_push = 1'b0;
      chk("push_pop_full_count", tf_count, 32'd16);
      chk("push_pop_full_overrun", tf_overrun, 32'd0);
      ena_mode = 1;
      wait_done(20000);

      // tx_reset in the middle of a data bit, with a push in the same clk
      mon_en = 1'b0;
      push_byte(8'h00);
      push_byte(8'h00);
      repeat (200) @(posedge clk);
      #1;
      chk("txr_pre_stx", stx_pad_o, 32'd0);
      chk("txr_pre_count", tf_count, 32'd1);
      @(posedge clk);
      #1;
      tx_reset   = 1'b1;
      tf_push    = 1'b1;
      tf_data_in = 8'h5A;
      @(posedge clk);
      #1;
      tx_reset = 1'b0;
      tf_push  = 1'b0;
      chk("txr_stx", stx_pad_o, 32'd1);
      chk("txr_count", tf_count, 32'd0);
      chk("txr_temt", temt, 32'd1);
      chk("txr_thre", thre, 32'd1);
      repeat (120) @(posedge clk);
      #1;
      chk("txr_stays_idle_stx", stx_pad_o, 32'd1);
      chk("txr_stays_idle_count", tf_count, 32'd0);
      mon_en = 1'b1;
      expect_frame(9'h0C3, 8, 16, 1'b1, 1'b0);
      push_byte(8'hC3);
      wait_done(4000);

      // break during a frame of all-ones data
      mon_en = 1'b0;
      push_byte(8'hFF);
      seen = 1'b0;
      t0   = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (stx_pad_o === 1'b0) begin
            seen = 1'b1;
            t0   = clk_no;
         end
      end
      chk("brk_frame_started", seen, 32'd1);
      @(posedge clk);
      #1;
      lcr = 8'h43;
      bad = 0;
      repeat (160) begin
         @(negedge clk);
         if (stx_pad_o !== 1'b0) bad++;
      end
      chk("brk_line_low", bad, 32'd0);
      @(posedge clk);
      #1;
      lcr = 8'h03;
      @(posedge clk);
      #1;
      chk("brk_release", stx_pad_o, 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         @(negedge clk);
         if (temt === 1'b1) seen = 1'b1;
      end
      chk("brk_frame_len_clk", clk_no - t0, 32'd640);
      chk("brk_fifo_consumed", tf_count, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
